vme64x_csr_decoder: RTL and testbench

- Slave-side function decoder and CSR block for a VME64x carrier.
- Takes single-cycle VME accesses that the bus PHY/handshake logic has already synchronised into the system clock domain.
- Implements the CR/CSR registers needed for configuration: ADER for functions 0 and 1, the WB32 mode bit, and BIT_SET/BIT_CLR module enable.
- Forwards decoded A24/A32 data accesses to an internal Wishbone master port, which feeds the node-core interconnect.

---
 rtl/vme64x_pkg.sv | 53 +++++
 rtl/vme64x_func_match.sv | 33 +++
 rtl/vme64x_csr_decoder.sv | 180 ++++++++++++++++++
 tb/tb_vme64x_csr_decoder.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vme64x_pkg.sv
// Shared constants, CSR map and state encoding for the VME64x CSR/function decoder.
package vme64x_pkg;

  localparam logic [5:0] c_AM_CSR          = 6'h2F;
  localparam logic [5:0] c_AM_A24_USR_DATA = 6'h39;
  localparam logic [5:0] c_AM_A24_USR_PROG = 6'h3A;
  localparam logic [5:0] c_AM_A24_SUP_DATA = 6'h3D;
  localparam logic [5:0] c_AM_A24_SUP_PROG = 6'h3E;
  localparam logic [5:0] c_AM_A32_USR_DATA = 6'h09;
  localparam logic [5:0] c_AM_A32_USR_PROG = 6'h0A;
  localparam logic [5:0] c_AM_A32_SUP_DATA = 6'h0D;
  localparam logic [5:0] c_AM_A32_SUP_PROG = 6'h0E;

  localparam int unsigned c_CSR_OFF_WIDTH = 19;
  localparam logic [18:0] c_CSR_ADER0     = 19'h7FF63;
  localparam logic [18:0] c_CSR_WB32      = 19'h7FF33;
  localparam logic [18:0] c_CSR_BIT_SET   = 19'h7FFFB;
  localparam logic [18:0] c_CSR_BIT_CLR   = 19'h7FFF7;
  localparam int unsigned c_CSR_ADER_STRIDE      = 16;
  localparam int unsigned c_CSR_ADER_BYTE_STRIDE = 4;

  localparam int unsigned c_ADER_XAM      = 0;
  localparam int unsigned c_ADER_DFS      = 1;
  localparam int unsigned c_ADER_AM_LSB   = 2;
  localparam int unsigned c_ADER_AM_MSB   = 7;
  localparam int unsigned c_ADER_ADDR_LSB = 8;
  localparam int unsigned c_BIT_ENABLE    = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_WB   = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  function automatic logic is_a24_am(input logic [5:0] am);
    return am inside {c_AM_A24_USR_DATA, c_AM_A24_USR_PROG,
                      c_AM_A24_SUP_DATA, c_AM_A24_SUP_PROG};
  endfunction

  function automatic logic is_a32_am(input logic [5:0] am);
    return am inside {c_AM_A32_USR_DATA, c_AM_A32_USR_PROG,
                      c_AM_A32_SUP_DATA, c_AM_A32_SUP_PROG};
  endfunction

  // CSR offset of ADER n byte k (k = 0 is the most significant byte)
  function automatic logic [18:0] ader_byte_off(input int unsigned n, input int unsigned k);
    int unsigned off;
    off = 32'(c_CSR_ADER0) + c_CSR_ADER_STRIDE * n + c_CSR_ADER_BYTE_STRIDE * k;
    return 19'(off);
  endfunction

endpackage

// File: rtl/vme64x_func_match.sv
// Compares one ADER against the incoming address/AM; flags a window hit.
module vme64x_func_match
  import vme64x_pkg::*;
#(
  parameter int unsigned g_func_win_bits = 20
) (
  input  logic [31:0] ader,
  input  logic [31:0] addr,
  input  logic [5:0]  am,
  output logic        match_c
);

  logic [5:0] ader_am;
  logic       func_enabled;
  logic       a24_hit;
  logic       a32_hit;
  logic       unused_bits;

  assign ader_am      = ader[c_ADER_AM_MSB:c_ADER_AM_LSB];
  assign func_enabled = !ader[c_ADER_XAM] && (ader_am != 6'h00);

  assign a24_hit = is_a24_am(am) &&
                   (addr[23:g_func_win_bits] == ader[23:g_func_win_bits]);
  assign a32_hit = is_a32_am(am) &&
                   (addr[31:g_func_win_bits] == ader[31:g_func_win_bits]);

  assign match_c = func_enabled && (am == ader_am) && (a24_hit || a32_hit);

  // DFS and sub-window bits take no part in the compare
  assign unused_bits = ^{ader[c_ADER_DFS], ader[g_func_win_bits-1:c_ADER_ADDR_LSB],
                         addr[g_func_win_bits-1:0]};

endmodule

// File: rtl/vme64x_csr_decoder.sv
// VME64x slave CR/CSR block and function decoder bridging data accesses to Wishbone.
module vme64x_csr_decoder
  import vme64x_pkg::*;
#(
  parameter int unsigned g_num_func      = 2,
  parameter int unsigned g_wb_addr_width = 32,
  parameter int unsigned g_func_win_bits = 20
) (
  input  logic                       clk_sys_i,
  input  logic                       rst_i,
  input  logic                       acc_stb_i,
  input  logic [31:0]                acc_addr_i,
  input  logic [5:0]                 acc_am_i,
  input  logic                       acc_we_i,
  input  logic [31:0]                acc_data_i,
  output logic [31:0]                acc_data_o,
  output logic                       acc_ack_o,
  output logic                       acc_err_o,
  output logic                       wb_cyc_o,
  output logic                       wb_stb_o,
  output logic                       wb_we_o,
  output logic [g_wb_addr_width-1:0] wb_adr_o,
  output logic [31:0]                wb_dat_o,
  output logic [3:0]                 wb_sel_o,
  input  logic [31:0]                wb_dat_i,
  input  logic                       wb_ack_i,
  input  logic                       wb_err_i,
  output logic                       module_enable_o,
  output logic                       wb32_o
);

  localparam logic [31:0] c_WIN_MASK = 32'((64'd1 << g_func_win_bits) - 64'd1);

  state_t state;
  state_t next_state;

  logic [31:0]           ader_q [g_num_func];
  logic [g_num_func-1:0] match_vec;
  logic [18:0]           csr_off;
  logic                  csr_sel;
  logic                  csr_wr;
  logic                  data_hit;
  logic [7:0]            csr_rbyte;

  logic                       ack_nxt;
  logic                       err_nxt;
  logic                       cyc_nxt;
  logic                       we_nxt;
  logic [3:0]                 sel_nxt;
  logic [31:0]                rdata_nxt;
  logic [g_wb_addr_width-1:0] adr_nxt;
  logic [31:0]                wdat_nxt;

  assign csr_off  = acc_addr_i[c_CSR_OFF_WIDTH-1:0];
  assign csr_sel  = (acc_am_i == c_AM_CSR);
  assign csr_wr   = (state == ST_IDLE) && acc_stb_i && csr_sel && acc_we_i;
  assign data_hit = module_enable_o && (|match_vec);

  for (genvar gi = 0; gi < int'(g_num_func); gi++) begin : g_match
    vme64x_func_match #(
      .g_func_win_bits(g_func_win_bits)
    ) u_match (
      .ader    (ader_q[gi]),
      .addr    (acc_addr_i),
      .am      (acc_am_i),
      .match_c (match_vec[gi])
    );
  end

  // CSR byte read mux; unmapped offsets return zero
  always_comb begin
    csr_rbyte = 8'h00;
    for (int unsigned n = 0; n < g_num_func; n++) begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (csr_off == ader_byte_off(n, k)) csr_rbyte = ader_q[n][8*(3-k) +: 8];
      end
    end
    if (csr_off == c_CSR_WB32) csr_rbyte = {7'b0, wb32_o};
    if (csr_off == c_CSR_BIT_SET || csr_off == c_CSR_BIT_CLR)
      csr_rbyte = 8'(module_enable_o) << c_BIT_ENABLE;
  end

  always_ff @(posedge clk_sys_i) begin
    if (rst_i) begin
      for (int unsigned n = 0; n < g_num_func; n++) ader_q[n] <= '0;
      wb32_o          <= 1'b0;
      module_enable_o <= 1'b0;
    end else if (csr_wr) begin
      for (int unsigned n = 0; n < g_num_func; n++) begin
        for (int unsigned k = 0; k < 4; k++) begin
          if (csr_off == ader_byte_off(n, k)) ader_q[n][8*(3-k) +: 8] <= acc_data_i[7:0];
        end
      end
      if (csr_off == c_CSR_WB32) wb32_o <= acc_data_i[0];
      if (csr_off == c_CSR_BIT_SET && acc_data_i[c_BIT_ENABLE]) module_enable_o <= 1'b1;
      if (csr_off == c_CSR_BIT_CLR && acc_data_i[c_BIT_ENABLE]) module_enable_o <= 1'b0;
    end
  end

  always_ff @(posedge clk_sys_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (acc_stb_i) begin
          if (csr_sel)       next_state = ST_ACK;
          else if (data_hit) next_state = ST_WB;
          else               next_state = ST_ERR;
        end
      end
      ST_WB: begin
        if (wb_ack_i)      next_state = ST_ACK;
        else if (wb_err_i) next_state = ST_ERR;
      end
      ST_ACK:  next_state = ST_IDLE;
      ST_ERR:  next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // Next values of the registered bus outputs, keyed on the state being entered
  always_comb begin
    ack_nxt   = 1'b0;
    err_nxt   = 1'b0;
    cyc_nxt   = 1'b0;
    we_nxt    = 1'b0;
    sel_nxt   = 4'h0;
    rdata_nxt = acc_data_o;
    adr_nxt   = wb_adr_o;
    wdat_nxt  = wb_dat_o;
    case (next_state)
      ST_ACK: ack_nxt = 1'b1;
      ST_ERR: err_nxt = 1'b1;
      ST_WB: begin
        cyc_nxt = 1'b1;
        sel_nxt = 4'hF;
        we_nxt  = wb_we_o;
      end
      default: ;
    endcase
    if (state == ST_IDLE && acc_stb_i) begin
      if (csr_sel) rdata_nxt = acc_we_i ? 32'h0 : {24'h0, csr_rbyte};
      if (next_state == ST_WB) begin
        adr_nxt  = g_wb_addr_width'(acc_addr_i & c_WIN_MASK);
        wdat_nxt = acc_data_i;
        we_nxt   = acc_we_i;
      end
    end
    if (state == ST_WB && wb_ack_i) rdata_nxt = wb_dat_i;
  end

  always_ff @(posedge clk_sys_i) begin
    if (rst_i) begin
      acc_ack_o  <= 1'b0;
      acc_err_o  <= 1'b0;
      acc_data_o <= '0;
      wb_cyc_o   <= 1'b0;
      wb_stb_o   <= 1'b0;
      wb_we_o    <= 1'b0;
      wb_sel_o   <= '0;
      wb_adr_o   <= '0;
      wb_dat_o   <= '0;
    end else begin
      acc_ack_o  <= ack_nxt;
      acc_err_o  <= err_nxt;
      acc_data_o <= rdata_nxt;
      wb_cyc_o   <= cyc_nxt;
      wb_stb_o   <= cyc_nxt;
      wb_we_o    <= we_nxt;
      wb_sel_o   <= sel_nxt;
      wb_adr_o   <= adr_nxt;
      wb_dat_o   <= wdat_nxt;
    end
  end

endmodule

// File: tb/tb_vme64x_csr_decoder.sv
// Randomised bench for vme64x_csr_decoder against a behavioural CSR/decode model.
module tb_vme64x_csr_decoder;

  localparam int K_CSR = 0;
  localparam int K_WB  = 1;
  localparam int K_ERR = 2;

  logic        clk_sys_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        acc_stb_i = 1'b0;
  logic [31:0] acc_addr_i = '0;
  logic [5:0]  acc_am_i = '0;
  logic        acc_we_i = 1'b0;
  logic [31:0] acc_data_i = '0;
  logic [31:0] acc_data_o;
  logic        acc_ack_o, acc_err_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i = '0;
  logic        wb_ack_i = 1'b0, wb_err_i = 1'b0;
  logic        module_enable_o, wb32_o;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] ader_m [2];
  bit          en_m;
  bit          wb32_m;
  logic [7:0]  lsb_tab [7];

  vme64x_csr_decoder dut (
    .clk_sys_i       (clk_sys_i),
    .rst_i           (rst_i),
    .acc_stb_i       (acc_stb_i),
    .acc_addr_i      (acc_addr_i),
    .acc_am_i        (acc_am_i),
    .acc_we_i        (acc_we_i),
    .acc_data_i      (acc_data_i),
    .acc_data_o      (acc_data_o),
    .acc_ack_o       (acc_ack_o),
    .acc_err_o       (acc_err_o),
    .wb_cyc_o        (wb_cyc_o),
    .wb_stb_o        (wb_stb_o),
    .wb_we_o         (wb_we_o),
    .wb_adr_o        (wb_adr_o),
    .wb_dat_o        (wb_dat_o),
    .wb_sel_o        (wb_sel_o),
    .wb_dat_i        (wb_dat_i),
    .wb_ack_i        (wb_ack_i),
    .wb_err_i        (wb_err_i),
    .module_enable_o (module_enable_o),
    .wb32_o          (wb32_o)
  );

  always #5 clk_sys_i = ~clk_sys_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    ader_m[0] = '0;
    ader_m[1] = '0;
    en_m      = 1'b0;
    wb32_m    = 1'b0;
  endtask

  function automatic int unsigned ader_off(input int n, input int k);
    return 32'h7FF63 + 32'(16 * n + 4 * k);
  endfunction

  function automatic logic [31:0] csr_read(input logic [18:0] off);
    if (32'(off) == 32'h7FF33) return {31'b0, wb32_m};
    if (32'(off) == 32'h7FFFB || 32'(off) == 32'h7FFF7) return en_m ? 32'h10 : 32'h0;
    for (int n = 0; n < 2; n++)
      for (int k = 0; k < 4; k++)
        if (32'(off) == ader_off(n, k)) return (ader_m[n] >> (24 - 8 * k)) & 32'hFF;
    return 32'h0;
  endfunction

  task automatic model_csr_write(input logic [18:0] off, input logic [7:0] d);
    if (32'(off) == 32'h7FF33) wb32_m = d[0];
    if (32'(off) == 32'h7FFFB && d[4]) en_m = 1'b1;
    if (32'(off) == 32'h7FFF7 && d[4]) en_m = 1'b0;
    for (int n = 0; n < 2; n++)
      for (int k = 0; k < 4; k++)
        if (32'(off) == ader_off(n, k))
          ader_m[n] = (ader_m[n] & ~(32'hFF << (24 - 8 * k))) | (32'(d) << (24 - 8 * k));
  endtask

  // Which response an access should get: CSR ack, Wishbone cycle, or bus error
  function automatic int predict(input logic [5:0] am, input logic [31:0] addr);
    logic [31:0] a;
    bit a24, a32;
    if (am == 6'h2F) return K_CSR;
    if (!en_m) return K_ERR;
    a24 = am inside {6'h39, 6'h3A, 6'h3D, 6'h3E};
    a32 = am inside {6'h09, 6'h0A, 6'h0D, 6'h0E};
    for (int n = 0; n < 2; n++) begin
      a = ader_m[n];
      if (a[0] || a[7:2] == 6'h00 || a[7:2] != am) continue;
      if (a24 && ((addr & 32'h00F0_0000) == (a & 32'h00F0_0000))) return K_WB;
      if (a32 && ((addr >> 20) == (a >> 20))) return K_WB;
    end
    return K_ERR;
  endfunction

  // One VME access, acting as the Wishbone slave; called just after a rising edge
  task automatic access(input logic [5:0] am, input logic [31:0] addr, input logic we,
                        input logic [31:0] wdata, input bit allow_err);
    int kind, lat, lat0, cyc_cnt;
    bit use_err, saw_cyc, done, responded, got_ack, got_err, cyc_at_done;
    logic [31:0] exp_rd, wb_rd, got_data;
    kind     = predict(am, addr);
    exp_rd   = csr_read(addr[18:0]);
    lat      = int'($urandom_range(0, 3));
    lat0     = lat;
    use_err  = allow_err && ($urandom_range(0, 7) == 0);
    wb_rd    = $urandom;
    saw_cyc  = 0; done = 0; responded = 0; got_ack = 0; got_err = 0;
    cyc_at_done = 0; cyc_cnt = 0; got_data = '0;
    acc_stb_i = 1'b1; acc_am_i = am; acc_addr_i = addr; acc_we_i = we; acc_data_i = wdata;
    @(posedge clk_sys_i); #1;
    acc_stb_i = 1'b0; acc_addr_i = $urandom; acc_data_i = $urandom;
    for (int c = 1; c <= 16 && !done; c++) begin
      if (acc_ack_o || acc_err_o) begin
        done = 1; got_ack = acc_ack_o; got_err = acc_err_o; cyc_cnt = c;
        got_data = acc_data_o; cyc_at_done = wb_cyc_o;
      end else if (wb_cyc_o && !responded) begin
        if (!saw_cyc) begin
          check("wb_adr", wb_adr_o, addr & 32'h000F_FFFF);
          check("wb_we", 32'(wb_we_o), 32'(we));
          check("wb_stb", 32'(wb_stb_o), 32'h1);
          check("wb_sel", 32'(wb_sel_o), 32'hF);
          if (we) check("wb_dat", wb_dat_o, wdata);
        end
        saw_cyc = 1;
        if (lat == 0) begin
          responded = 1;
          wb_dat_i  = wb_rd;
          if (use_err) wb_err_i = 1'b1;
          else         wb_ack_i = 1'b1;
        end else lat--;
      end
      if (!done) begin
        @(posedge clk_sys_i); #1;
        wb_ack_i = 1'b0; wb_err_i = 1'b0;
      end
    end
    check("done", 32'(done), 32'h1);
    case (kind)
      K_CSR: begin
        check("csr_ack", 32'(got_ack), 32'h1);
        check("csr_lat", 32'(cyc_cnt), 32'h1);
        check("csr_nocyc", 32'(saw_cyc), 32'h0);
        if (!we) check("csr_rd", got_data, exp_rd);
        else     model_csr_write(addr[18:0], wdata[7:0]);
      end
      K_ERR: begin
        check("dec_err", 32'(got_err), 32'h1);
        check("err_lat", 32'(cyc_cnt), 32'h1);
        check("err_nocyc", 32'(saw_cyc), 32'h0);
      end
      default: begin
        check("wb_cyc_seen", 32'(saw_cyc), 32'h1);
        check("wb_lat", 32'(cyc_cnt), 32'(lat0 + 2));
        check("wb_drop", 32'(cyc_at_done), 32'h0);
        check("wb_ack", 32'(got_ack), 32'(!use_err));
        check("wb_err", 32'(got_err), 32'(use_err));
        if (!we && !use_err) check("wb_rd", got_data, wb_rd);
      end
    endcase
    @(posedge clk_sys_i); #1;
    check("pulse", 32'({acc_ack_o, acc_err_o}), 32'h0);
  endtask

  task automatic csr_write(input logic [18:0] off, input logic [7:0] d);
    access(6'h2F, {13'h0, off}, 1'b1, {24'h0, d}, 1'b0);
  endtask

  task automatic csr_read_chk(input logic [18:0] off);
    access(6'h2F, {13'h0, off}, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic program_ader1();
    csr_write(19'h7FF73, 8'h00);
    csr_write(19'h7FF77, 8'hC0);
    csr_write(19'h7FF7B, 8'h00);
    csr_write(19'h7FF7F, 8'hE4);
  endtask

  initial begin
    logic [18:0] off;
    logic [7:0]  d;
    logic [5:0]  am;
    logic [31:0] addr;
    int          r, n;

    lsb_tab[0] = 8'hE4; lsb_tab[1] = 8'hF4; lsb_tab[2] = 8'h24; lsb_tab[3] = 8'h34;
    lsb_tab[4] = 8'hE5; lsb_tab[5] = 8'h00; lsb_tab[6] = 8'hE8;
    model_reset();

    repeat (3) @(posedge clk_sys_i);
    #1;
    check("rst_ack", 32'(acc_ack_o), 32'h0);
    check("rst_err", 32'(acc_err_o), 32'h0);
    check("rst_cyc", 32'(wb_cyc_o), 32'h0);
    check("rst_en", 32'(module_enable_o), 32'h0);
    check("rst_wb32", 32'(wb32_o), 32'h0);
    check("rst_data", acc_data_o, 32'h0);
    check("rst_adr", wb_adr_o, 32'h0);
    rst_i = 1'b0;
    @(posedge clk_sys_i); #1;

    program_ader1();
    csr_write(19'h7FF63, 8'h00);
    csr_write(19'h7FF67, 8'h00);
    csr_write(19'h7FF6B, 8'h00);
    csr_write(19'h7FF6F, 8'h01);
    for (int k = 0; k < 4; k++) csr_read_chk(19'(ader_off(1, k)));
    csr_read_chk(19'h7FF6F);
    csr_read_chk(19'h12345);

    access(6'h39, 32'h00C1_1000, 1'b1, 32'h1000_0000, 1'b0);

    csr_write(19'h7FF33, 8'h01);
    csr_write(19'h7FFFB, 8'h10);
    check("wb32_set", 32'(wb32_o), 32'h1);
    check("enable_set", 32'(module_enable_o), 32'h1);
    csr_read_chk(19'h7FF33);

    access(6'h39, 32'h00C1_1000, 1'b1, 32'h1000_0000, 1'b0);
    access(6'h39, 32'h00C1_1004, 1'b1, 32'h0000_0000, 1'b0);
    access(6'h39, 32'h00C6_0224, 1'b1, 32'h0001_0000, 1'b0);
    access(6'h39, 32'h00C6_0224, 1'b0, 32'h0, 1'b0);
    access(6'h39, 32'h00D0_0000, 1'b1, 32'h1, 1'b0);
    csr_write(19'h7FFF7, 8'h10);
    check("enable_clr", 32'(module_enable_o), 32'h0);
    access(6'h39, 32'h00C1_1000, 1'b1, 32'h1000_0000, 1'b0);

    csr_write(19'h7FFFB, 8'h10);
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 9) < 3) begin
        r = int'($urandom_range(0, 11));
        d = 8'($urandom);
        if (r < 8) begin
          off = 19'(ader_off(r / 4, r % 4));
          if (r % 4 == 3) d = lsb_tab[$urandom_range(0, 6)];
        end else if (r == 8)  off = 19'h7FF33;
        else if (r == 9)      off = 19'h7FFFB;
        else if (r == 10)     off = 19'h7FFF7;
        else                  off = 19'($urandom);
        access(6'h2F, {13'($urandom), off}, 1'($urandom), {24'($urandom), d}, 1'b1);
      end else begin
        r = int'($urandom_range(0, 9));
        case (r)
          0: am = 6'h39; 1: am = 6'h3A; 2: am = 6'h3D; 3: am = 6'h3E;
          4: am = 6'h09; 5: am = 6'h0A; 6: am = 6'h0D; 7: am = 6'h0E;
          default: am = 6'($urandom);
        endcase
        n = int'($urandom_range(0, 1));
        addr = $urandom;
        if ($urandom_range(0, 3) != 0) addr = (ader_m[n] & 32'hFFF0_0000) | (addr & 32'h000F_FFFF);
        access(am, addr, 1'($urandom), $urandom, 1'b1);
      end
    end

    // Reset in the middle of a Wishbone cycle
    program_ader1();
    csr_write(19'h7FFFB, 8'h10);
    acc_stb_i = 1'b1; acc_am_i = 6'h39; acc_addr_i = 32'h00C1_1000;
    acc_we_i = 1'b1; acc_data_i = 32'h5A5A_0000;
    @(posedge clk_sys_i); #1;
    acc_stb_i = 1'b0;
    check("mid_cyc", 32'(wb_cyc_o), 32'h1);
    rst_i = 1'b1;
    @(posedge clk_sys_i); #1;
    model_reset();
    check("rst_mid_cyc", 32'(wb_cyc_o), 32'h0);
    check("rst_mid_ack", 32'(acc_ack_o), 32'h0);
    check("rst_mid_en", 32'(module_enable_o), 32'(en_m));
    rst_i = 1'b0;
    @(posedge clk_sys_i); #1;
    check("rst_after_ack", 32'(acc_ack_o), 32'h0);
    access(6'h39, 32'h00C1_1000, 1'b1, 32'h0, 1'b0);
    csr_read_chk(19'h7FF7F);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
